// File: rtl/mat_vec_seq_if.sv
// Bundles the job request, weight-memory port and result bus of mat_vec_seq.
// The master side issues jobs and serves weights. The slave side is the engine.
interface mat_vec_seq_if #(
    parameter int N    = 32,
    parameter int ROWS = 16,
    parameter int COLS = 16
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic                 start;
    logic signed [N-1:0]  vec_in  [COLS];
    logic signed [N-1:0]  bias_in [ROWS];
    logic                 w_rd_en;
    logic [RW-1:0]        w_row;
    logic [CW-1:0]        w_col;
    logic signed [N-1:0]  w_data;
    logic signed [N-1:0]  out     [ROWS];
    logic                 busy;
    logic                 done;
    logic                 out_valid;

    modport master (
        output start, vec_in, bias_in, w_data,
        input  w_rd_en, w_row, w_col, out, busy, done, out_valid
    );

    modport slave (
        input  start, vec_in, bias_in, w_data,
        output w_rd_en, w_row, w_col, out, busy, done, out_valid
    );
endinterface

// File: rtl/mat_vec_seq.sv
// Sequential fixed-point matrix-vector multiply: out = relu(W * vec + bias).
// One weight is read per cycle in row-major order from a memory with a fixed
// one-cycle read latency. One product is accumulated per returned weight.
module mat_vec_seq #(
    parameter int N    = 32,
    parameter int ROWS = 16,
    parameter int COLS = 16,
    parameter int FRAC = 11,
    parameter int RELU = 1
) (
    input  logic         clk,
    input  logic         rst,
    mat_vec_seq_if.slave bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW = 2 * N;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_DONE} state_t;

    state_t              state_q,     state_d;
    logic [RW-1:0]       row_q,       row_d;
    logic [CW-1:0]       col_q,       col_d;
    logic                rd_vld_q,    rd_vld_d;
    logic [RW-1:0]       rd_row_q,    rd_row_d;
    logic [CW-1:0]       rd_col_q,    rd_col_d;
    logic                w_rd_en_q,   w_rd_en_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                out_valid_q, out_valid_d;
    logic signed [N-1:0] acc_q,       acc_d;
    logic signed [N-1:0] vec_q  [COLS];
    logic signed [N-1:0] vec_d  [COLS];
    logic signed [N-1:0] bias_q [ROWS];
    logic signed [N-1:0] bias_d [ROWS];
    logic signed [N-1:0] out_q  [ROWS];
    logic signed [N-1:0] out_d  [ROWS];

    logic signed [PW-1:0] w_ext;
    logic signed [PW-1:0] v_ext;
    logic signed [PW-1:0] prod_full;
    logic signed [N-1:0]  prod_n;
    logic signed [N-1:0]  acc_base;
    logic signed [N-1:0]  sum_n;
    logic signed [N-1:0]  res_n;

    // Sequencer: job acceptance, row-major address generation, completion.
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        rd_vld_d    = 1'b0;
        rd_row_d    = rd_row_q;
        rd_col_d    = rd_col_q;
        w_rd_en_d   = w_rd_en_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        vec_d       = vec_q;
        bias_d      = bias_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    vec_d       = bus.vec_in;
                    bias_d      = bus.bias_in;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b1;
                    w_rd_en_d   = 1'b1;
                    row_d       = '0;
                    col_d       = '0;
                    state_d     = S_MAC;
                end
            end
            S_MAC: begin
                // The address on the bus this cycle returns data next cycle.
                rd_vld_d = 1'b1;
                rd_row_d = row_q;
                rd_col_d = col_q;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        row_d     = '0;
                        w_rd_en_d = 1'b0;
                        state_d   = S_DRAIN;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            S_DRAIN: begin
                // The last weight lands this cycle, so the final row is written at this edge.
                state_d     = S_DONE;
                done_d      = 1'b1;
                out_valid_d = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: scaled product, row accumulation, bias and ReLU on the last column.
    always_comb begin
        w_ext     = PW'(bus.w_data);
        v_ext     = PW'(vec_q[rd_col_q]);
        prod_full = w_ext * v_ext;
        prod_n    = N'(prod_full >>> FRAC);
        acc_base  = (rd_col_q == '0) ? '0 : acc_q;
        sum_n     = acc_base + prod_n;
        res_n     = sum_n + bias_q[rd_row_q];
        if (RELU != 0 && res_n[N-1]) begin
            res_n = '0;
        end

        acc_d = acc_q;
        out_d = out_q;
        if (rd_vld_q) begin
            acc_d = sum_n;
            if (rd_col_q == COL_LAST) begin
                out_d[rd_row_q] = res_n;
            end
        end
    end

    // Control and result registers, all cleared by the synchronous reset.
    // NOTE: state is updated with non-blocking assignments, so every flop samples
    // the values from before the edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            rd_vld_q    <= 1'b0;
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            w_rd_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            for (int i = 0; i < ROWS; i++) begin
                out_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rd_vld_q    <= rd_vld_d;
            rd_row_q    <= rd_row_d;
            rd_col_q    <= rd_col_d;
            w_rd_en_q   <= w_rd_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
        end
    end

    // Operand latches for the vector and bias of the running job.
    // NOTE: these arrays have no reset. They are always reloaded on an accepted
    // start before any use, so they can stay plain enable registers.
    always_ff @(posedge clk) begin
        vec_q  <= vec_d;
        bias_q <= bias_d;
    end

    assign bus.w_rd_en   = w_rd_en_q;
    assign bus.w_row     = row_q;
    assign bus.w_col     = col_q;
    assign bus.out       = out_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mat_vec_seq.sv
// Directed bench for mat_vec_seq. The main instance is 16x16 with ReLU.
// A second instance is 1x16 without ReLU and covers negative outputs and ROWS=1.
module tb_mat_vec_seq;
    localparam int N    = 32;
    localparam int R    = 16;
    localparam int C    = 16;
    localparam int C1   = 16;
    localparam int FRAC = 11;
    localparam logic signed [N-1:0] JUNK = 32'sh0123_4567;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mat_vec_seq_if #(.N(N), .ROWS(R), .COLS(C)) bus ();
    mat_vec_seq #(.N(N), .ROWS(R), .COLS(C), .FRAC(FRAC), .RELU(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mat_vec_seq_if #(.N(N), .ROWS(1), .COLS(C1)) bus1 ();
    mat_vec_seq #(.N(N), .ROWS(1), .COLS(C1), .FRAC(FRAC), .RELU(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    logic signed [N-1:0] w_mem  [R][C];
    logic signed [N-1:0] w1_mem [C1];
    logic signed [N-1:0] exp_out [R];
    int rd_cnt   = 0;
    int addr_err = 0;
    int exp_idx  = 0;

    // Weight memory with one-cycle latency. It also checks the row-major address order.
    always @(posedge clk) begin
        if (bus.start && !bus.busy) begin
            rd_cnt   <= 0;
            addr_err <= 0;
            exp_idx  <= 0;
        end else if (bus.w_rd_en) begin
            if (int'(bus.w_row) != exp_idx / C || int'(bus.w_col) != exp_idx % C)
                addr_err <= addr_err + 1;
            exp_idx <= exp_idx + 1;
            rd_cnt  <= rd_cnt + 1;
        end
        bus.w_data <= bus.w_rd_en ? w_mem[bus.w_row][bus.w_col] : JUNK;
    end

    always @(posedge clk) bus1.w_data <= bus1.w_rd_en ? w1_mem[bus1.w_col] : JUNK;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic fill_w(input int v);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) w_mem[r][c] = v;
    endtask

    task automatic set_identity();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) w_mem[r][c] = (r == c) ? 2048 : 0;
    endtask

    // Start a job, optionally pulse start again mid-job, then wait for done and check.
    task automatic run_job(input string tag, input int glitch_at, output int lat, output int done_at);
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        check({tag, ".busy_t1"}, bus.busy, 1);
        check({tag, ".rd_en_t1"}, bus.w_rd_en, 1);
        check({tag, ".ov_clr"}, bus.out_valid, 0);
        lat = 1;
        while (!bus.done && lat < 400) begin
            @(negedge clk);
            lat++;
            if (lat == glitch_at) begin
                bus.start = 1'b1;
                for (int i = 0; i < C; i++) bus.vec_in[i] = 7;
            end else if (lat == glitch_at + 1) begin
                bus.start = 1'b0;
            end
        end
        done_at = cyc;
        check({tag, ".lat"}, lat, 258);
        check({tag, ".rd_cnt"}, rd_cnt, 256);
        check({tag, ".addr_err"}, addr_err, 0);
        check({tag, ".ov"}, bus.out_valid, 1);
        check({tag, ".busy_done"}, bus.busy, 1);
        for (int i = 0; i < R; i++)
            check($sformatf("%s.out[%0d]", tag, i), bus.out[i], exp_out[i]);
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        check({tag, ".done_drop"}, bus.done, 0);
        check({tag, ".busy_drop"}, bus.busy, 0);
        check({tag, ".ov_hold"}, bus.out_valid, 1);
        check({tag, ".rd_en_idle"}, bus.w_rd_en, 0);
    endtask

    task automatic run_job1(input string tag, input int exp);
        int lat;
        @(negedge clk); bus1.start = 1'b1;
        @(negedge clk); bus1.start = 1'b0;
        lat = 1;
        while (!bus1.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, lat, 18);
        check({tag, ".ov"}, bus1.out_valid, 1);
        check({tag, ".out"}, bus1.out[0], exp);
    endtask

    initial begin
        int lat, d0, d1, d2, done_cnt;
        bus.start  = 1'b0;
        bus1.start = 1'b0;
        for (int i = 0; i < C; i++) bus.vec_in[i] = 0;
        for (int i = 0; i < R; i++) bus.bias_in[i] = 0;
        for (int i = 0; i < C1; i++) bus1.vec_in[i] = 0;
        bus1.bias_in[0] = 0;

        // Reset state while rst is held.
        repeat (3) @(negedge clk);
        check("rst.busy", bus.busy, 0);
        check("rst.done", bus.done, 0);
        check("rst.ov", bus.out_valid, 0);
        check("rst.rd_en", bus.w_rd_en, 0);
        check("rst.out0", bus.out[0], 0);
        check("rst.out15", bus.out[R-1], 0);
        check("rst.d1_out", bus1.out[0], 0);
        rst = 1'b0;

        // Identity: out[i] = 2048*i.
        set_identity();
        for (int i = 0; i < C; i++) bus.vec_in[i] = 2048 * i;
        for (int i = 0; i < R; i++) exp_out[i] = 2048 * i;
        run_job("ident", -1, lat, d0);
        after_done("ident");

        // Truncation: 3*1000 >> 11 = 1 per product, 16 per row.
        fill_w(3);
        for (int i = 0; i < C; i++) bus.vec_in[i] = 1000;
        for (int i = 0; i < R; i++) exp_out[i] = 16;
        run_job("trunc", -1, lat, d0);
        after_done("trunc");

        // Floor toward -inf gives -2 per product, sum -32, clamped to 0.
        fill_w(-3);
        for (int i = 0; i < R; i++) exp_out[i] = 0;
        run_job("relu", -1, lat, d0);

        // Bias only: out[i] = max(i-8, 0).
        fill_w(0);
        for (int i = 0; i < R; i++) begin
            bus.bias_in[i] = i - 8;
            exp_out[i] = (i > 8) ? i - 8 : 0;
        end
        run_job("bias", -1, lat, d0);
        for (int i = 0; i < R; i++) bus.bias_in[i] = 0;

        // A second start at t0+50 with a different vector must be ignored.
        set_identity();
        for (int i = 0; i < C; i++) bus.vec_in[i] = 2048 * i;
        for (int i = 0; i < R; i++) exp_out[i] = 2048 * i;
        run_job("busy_start", 50, lat, d0);
        after_done("busy_start");

        // Reset at t0+100 aborts the job and clears the outputs.
        for (int i = 0; i < C; i++) bus.vec_in[i] = 2048 * i;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        lat = 1;
        while (lat < 99) begin
            @(negedge clk);
            lat++;
        end
        check("rst_mid.pre_out3", bus.out[3], 6144);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid.busy", bus.busy, 0);
        check("rst_mid.rd_en", bus.w_rd_en, 0);
        check("rst_mid.ov", bus.out_valid, 0);
        for (int i = 0; i < R; i++)
            check($sformatf("rst_mid.out[%0d]", i), bus.out[i], 0);
        rst = 1'b0;
        done_cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("rst_mid.no_done", done_cnt, 0);
        check("rst_mid.out3_held", bus.out[3], 0);

        fill_w(3);
        for (int i = 0; i < C; i++) bus.vec_in[i] = 1000;
        for (int i = 0; i < R; i++) exp_out[i] = 16;
        run_job("post_rst", -1, lat, d0);
        after_done("post_rst");

        // Back-to-back: the second start comes in the cycle after the first done.
        set_identity();
        for (int i = 0; i < C; i++) bus.vec_in[i] = 2048 * i;
        for (int i = 0; i < R; i++) exp_out[i] = 2048 * i;
        run_job("b2b_a", -1, lat, d1);
        for (int i = 0; i < C; i++) bus.vec_in[i] = 2048 * (15 - i);
        for (int i = 0; i < R; i++) exp_out[i] = 2048 * (15 - i);
        run_job("b2b_b", -1, lat, d2);
        check("b2b.period", d2 - d1, 259);
        after_done("b2b_b");

        // ROWS=1, no ReLU: negative results pass through.
        for (int i = 0; i < C1; i++) begin
            w1_mem[i] = -3;
            bus1.vec_in[i] = 1000;
        end
        bus1.bias_in[0] = 0;
        run_job1("d1_neg", -32);
        for (int i = 0; i < C1; i++) w1_mem[i] = 3;
        bus1.bias_in[0] = -20;
        run_job1("d1_bias", -4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mat_vec_seq.md
MAT_VEC_SEQ -- requirements
Module: mat_vec_seq

Interface
REQ-001 SHALL have parameter N, default 32: signed data width of weights, vector, bias and outputs.
REQ-002 SHALL have parameter ROWS, default 16: output length (matrix rows); minimum 1.
REQ-003 SHALL have parameter COLS, default 16: input length (matrix columns); minimum 1.
REQ-004 SHALL have parameter FRAC, default 11: fixed-point fraction bits; each product is shifted right arithmetically by FRAC.
REQ-005 SHALL have parameter RELU, default 1: 1 clamps negative results to 0; 0 passes signed results through.
REQ-006 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port start, input, 1: job request, sampled only in IDLE.
REQ-009 SHALL have port vec_in, input, signed N x [COLS]: input vector, latched on accepted start.
REQ-010 SHALL have port bias_in, input, signed N x [ROWS]: bias vector, latched on accepted start.
REQ-011 SHALL have port w_rd_en, output, 1: weight read strobe.
REQ-012 SHALL have port w_row, output, max(1,$clog2(ROWS)): weight row address.
REQ-013 SHALL have port w_col, output, max(1,$clog2(COLS)): weight column address.
REQ-014 SHALL have port w_data, input, signed N: weight for the address issued on the previous cycle (fixed 1-cycle read latency).
REQ-015 SHALL have port out, output, signed N x [ROWS]: registered results.
REQ-016 SHALL have port busy, output, 1: high from the cycle after start is accepted until the done cycle, inclusive.
REQ-017 SHALL have port done, output, 1: single-cycle completion pulse.
REQ-018 SHALL have port out_valid, output, 1: out holds a complete result set.

Function
REQ-019 SHALL implement FSM states IDLE, MAC, DRAIN, DONE: IDLE->MAC on start; MAC->DRAIN after the last read is issued; DRAIN->DONE after the last weight returns; DONE->IDLE unconditionally.
REQ-020 SHALL, on start=1 in IDLE (cycle t0), latch vec_in and bias_in, clear out_valid, and enter MAC at t0+1.
REQ-021 SHALL, in MAC, assert w_rd_en for exactly ROWS*COLS consecutive cycles (t0+1 .. t0+ROWS*COLS), issuing addresses in row-major order (col inner, row outer), one per cycle.
REQ-022 SHALL, for each returned w_data, form the full 2N-bit signed product w_data*vec[col], arithmetic-shift it right by FRAC (floor toward -inf), truncate it to N bits, and add it to an N-bit wrapping accumulator.
REQ-023 SHALL clear the accumulator at the first column of each row, with no lost or bubble cycle between rows.
REQ-024 SHALL, when a row's last product is accumulated, compute acc+bias[row] (N-bit wrap), apply ReLU if RELU=1 (result<0 -> 0; 0 stays 0), and write out[row] at that edge.
REQ-025 SHALL leave rows not yet written in the current job holding their previous values.
REQ-026 SHALL assert done and out_valid at cycle t0+ROWS*COLS+2; done lasts one cycle, and out_valid holds until the next accepted start or reset.
REQ-027 SHALL ignore start while busy is high, and SHALL not re-sample vec_in/bias_in during a job.
REQ-028 SHALL accept start in the cycle after done (back-to-back jobs), giving a job-to-job period of ROWS*COLS+3 cycles.
REQ-029 SHALL drive w_rd_en=0 outside MAC; w_row/w_col are don't-care when w_rd_en=0.
REQ-030 SHALL handle ROWS=1 and/or COLS=1 with identical latency formulas.

Reset
REQ-031 SHALL, while rst=1 at a clock edge, force FSM=IDLE, out all 0, busy=0, done=0, out_valid=0, w_rd_en=0, and clear accumulator and counters.
REQ-032 SHALL abort any job when rst=1 mid-operation, with no partial out update after reset.
REQ-033 SHALL give rst priority over a simultaneous start.

Verification
REQ-034 SHALL test identity: ROWS=COLS=16, diag weights 2048 (others 0), vec[i]=2048*i, bias=0 -> out[i]=2048*i, with done exactly 258 cycles after start.
REQ-035 SHALL test truncation and ReLU: all weights 3, vec=1000, bias=0 -> out=16 everywhere; all weights -3 -> each product -2, sum -32, out=0 (RELU=1) or -32 (RELU=0).
REQ-036 SHALL test bias: all weights 0, bias[i]=i-8 -> out[i]=max(i-8,0) with RELU=1.
REQ-037 SHALL test start while busy: a second start pulse at t0+50 -> ignored, done only at t0+258, and latched vec unchanged.
REQ-038 SHALL test reset mid-job: rst at t0+100 -> next cycle busy=0, out all 0, w_rd_en=0; a fresh start then completes normally.
REQ-039 SHALL test back-to-back jobs: start at the cycle after done -> second done 259 cycles after the first, with correct results.
